// File: rtl/common_pkg.sv
// Shared types for the memory arbiter: FSM states, owner tags
// and the registered request bundle.
package common;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } mem_owner_e;

  typedef struct packed {
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_type;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-outstanding memory arbiter.
// Data wins by default; a fetch starved STARVE_LIMIT grants wins.
module mem_arbiter
  import common::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_gnt,
  output logic              imem_rvalid,
  output logic [DATA_W-1:0] imem_rdata,
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [3:0]        dmem_be,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_gnt,
  output logic              dmem_rvalid,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  arb_state_e  state_q, state_d;
  mem_owner_e  owner_q, owner_d;
  mem_req_type req_q, req_d;
  logic [SW-1:0] starve_q, starve_d;
  logic pick_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      req_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      req_q    <= req_d;
      starve_q <= starve_d;
    end
  end

  assign pick_i = imem_req && (!dmem_req || starve_q == LIM);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    req_d       = req_q;
    starve_d    = starve_q;
    imem_gnt    = 1'b0;
    dmem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    dmem_rvalid = 1'b0;
    imem_rdata  = '0;
    dmem_rdata  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_be      = '0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        // gnt is combinational, so mask it while reset holds IDLE
        if (!reset && (imem_req || dmem_req)) begin
          state_d = WAIT;
          if (pick_i) begin
            imem_gnt = 1'b1;
            owner_d  = OWN_I;
            req_d    = '{we: 1'b0, be: 4'hF,
                         addr: imem_addr, wdata: '0};
            starve_d = '0;
          end else begin
            dmem_gnt = 1'b1;
            owner_d  = OWN_D;
            req_d    = '{we: dmem_we, be: dmem_be,
                         addr: dmem_addr, wdata: dmem_wdata};
            if (!imem_req)
              starve_d = '0;
            else if (starve_q != LIM)
              starve_d = starve_q + SW'(1);
          end
        end
      end
      WAIT: begin
        mem_req   = 1'b1;
        mem_we    = req_q.we;
        mem_be    = req_q.be;
        mem_addr  = req_q.addr;
        mem_wdata = req_q.wdata;
        if (mem_ready) state_d = RESP;
      end
      RESP: begin
        if (mem_rvalid) begin
          if (owner_q == OWN_I) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_rdata;
          end
          if (owner_q == OWN_D) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = mem_rdata;
          end
          state_d = IDLE;
          owner_d = OWN_NONE;
          req_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, starvation,
// ready stall and mid-transaction reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [169:0] all_out();
    return {imem_gnt, dmem_gnt, imem_rvalid, dmem_rvalid,
            mem_req, mem_we, mem_be, imem_rdata, dmem_rdata,
            mem_addr, mem_wdata};
  endfunction

  task automatic clear_inputs();
    imem_req = 0; imem_addr = 0;
    dmem_req = 0; dmem_we = 0; dmem_be = 0;
    dmem_addr = 0; dmem_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    imem_req = 1; dmem_req = 1; mem_ready = 1;
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (all_out() !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h want=0", all_out());
    end
    next_cycle();
    clear_inputs();
    reset = 0;
    #1;
    n_cmp++;
    if (all_out() !== '0) begin
      n_bad++;
      $display("FAIL reset_release got=%h want=0", all_out());
    end
  endtask

  task automatic test_lone_fetch();
    next_cycle();
    imem_req = 1; imem_addr = 32'h100; mem_ready = 1;
    #1;
    n_cmp++;
    if ({imem_gnt, dmem_gnt, mem_req} !== 3'b100) begin
      n_bad++;
      $display("FAIL fetch_c0 gnt/req got=%b want=100",
               {imem_gnt, dmem_gnt, mem_req});
    end
    next_cycle();
    imem_req = 0;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, mem_be, mem_addr, imem_gnt}
        !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b0}) begin
      n_bad++;
      $display("FAIL fetch_c1 req=%b we=%b be=%h addr=%h want 1 0 f 100",
               mem_req, mem_we, mem_be, mem_addr);
    end
    next_cycle();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if ({imem_rvalid, imem_rdata, dmem_rvalid, mem_req}
        !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL fetch_c2 rv=%b rdata=%h drv=%b req=%b want 1 deadbeef 0 0",
               imem_rvalid, imem_rdata, dmem_rvalid, mem_req);
    end
    next_cycle();
    mem_rvalid = 0; mem_rdata = 0;
    #1;
    n_cmp++;
    if ({imem_rvalid, dmem_rvalid, imem_rdata} !== '0) begin
      n_bad++;
      $display("FAIL fetch_c3 rv=%b drv=%b rdata=%h want 0",
               imem_rvalid, dmem_rvalid, imem_rdata);
    end
  endtask

  task automatic test_fetch_vs_store();
    next_cycle();
    imem_req = 1; imem_addr = 32'h300;
    dmem_req = 1; dmem_we = 1; dmem_be = 4'b0011;
    dmem_addr = 32'h200; dmem_wdata = 32'h1234;
    mem_ready = 1;
    #1;
    n_cmp++;
    if ({imem_gnt, dmem_gnt} !== 2'b01) begin
      n_bad++;
      $display("FAIL fvs_first_gnt got=%b want=01", {imem_gnt, dmem_gnt});
    end
    next_cycle();
    dmem_req = 0;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, imem_gnt}
        !== {1'b1, 1'b1, 4'b0011, 32'h200, 32'h1234, 1'b0}) begin
      n_bad++;
      $display("FAIL fvs_store req=%b we=%b be=%b addr=%h wd=%h ig=%b",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, imem_gnt);
    end
    next_cycle();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h55;
    #1;
    n_cmp++;
    if ({dmem_rvalid, dmem_rdata, imem_rvalid, imem_gnt, mem_req,
         mem_we, mem_be, mem_wdata}
        !== {1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL fvs_ack drv=%b drd=%h irv=%b ig=%b req=%b we=%b be=%h wd=%h",
               dmem_rvalid, dmem_rdata, imem_rvalid, imem_gnt, mem_req,
               mem_we, mem_be, mem_wdata);
    end
    next_cycle();
    mem_rvalid = 0; mem_rdata = 0; mem_ready = 1;
    #1;
    n_cmp++;
    if ({imem_gnt, dmem_gnt} !== 2'b10) begin
      n_bad++;
      $display("FAIL fvs_fetch_gnt got=%b want=10", {imem_gnt, dmem_gnt});
    end
    next_cycle();
    imem_req = 0;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata}
        !== {1'b1, 1'b0, 4'hF, 32'h300, 32'h0}) begin
      n_bad++;
      $display("FAIL fvs_fetch_req req=%b we=%b be=%h addr=%h wd=%h",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    next_cycle();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    #1;
    n_cmp++;
    if ({imem_rvalid, imem_rdata, dmem_rvalid}
        !== {1'b1, 32'h77, 1'b0}) begin
      n_bad++;
      $display("FAIL fvs_fetch_rv irv=%b ird=%h drv=%b want 1 77 0",
               imem_rvalid, imem_rdata, dmem_rvalid);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_starvation();
    logic [9:0] seq = '0;
    int ngnt = 0;
    int offslot = 0;
    next_cycle();
    imem_req = 1; imem_addr = 32'h40;
    dmem_req = 1; dmem_we = 0; dmem_addr = 32'h80;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (imem_gnt || dmem_gnt) begin
        if (c % 3 != 0 || (imem_gnt && dmem_gnt)) offslot++;
        if (ngnt < 10) seq[ngnt] = imem_gnt;
        ngnt++;
      end
      next_cycle();
    end
    clear_inputs();
    n_cmp++;
    if (ngnt !== 10) begin
      n_bad++;
      $display("FAIL starve_count got=%0d want=10", ngnt);
    end
    n_cmp++;
    if (seq !== 10'b10_0001_0000) begin
      n_bad++;
      $display("FAIL starve_order got=%b want=1000010000", seq);
    end
    n_cmp++;
    if (offslot !== 0) begin
      n_bad++;
      $display("FAIL starve_slot got=%0d want=0", offslot);
    end
  endtask

  task automatic test_ready_stall();
    int bad_cyc = 0;
    next_cycle();
    imem_req = 1; imem_addr = 32'h900;
    dmem_req = 1; dmem_addr = 32'h400; dmem_be = 4'hF;
    #1;
    n_cmp++;
    if ({imem_gnt, dmem_gnt} !== 2'b01) begin
      n_bad++;
      $display("FAIL stall_gnt got=%b want=01", {imem_gnt, dmem_gnt});
    end
    next_cycle();
    dmem_req = 0;
    for (int c = 0; c < 5; c++) begin
      mem_rvalid = (c == 2);
      mem_rdata = 32'hBAD;
      #1;
      if ({mem_req, mem_we, mem_be, mem_addr, imem_gnt, dmem_gnt,
           imem_rvalid, dmem_rvalid}
          !== {1'b1, 1'b0, 4'hF, 32'h400, 4'b0000})
        bad_cyc++;
      next_cycle();
    end
    n_cmp++;
    if (bad_cyc !== 0) begin
      n_bad++;
      $display("FAIL stall_stable bad_cycles=%0d want=0", bad_cyc);
    end
    mem_rvalid = 0; mem_ready = 1;
    #1;
    n_cmp++;
    if ({mem_req, mem_addr, imem_gnt} !== {1'b1, 32'h400, 1'b0}) begin
      n_bad++;
      $display("FAIL stall_ready req=%b addr=%h ig=%b",
               mem_req, mem_addr, imem_gnt);
    end
    next_cycle();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE;
    #1;
    n_cmp++;
    if ({mem_req, dmem_rvalid, dmem_rdata, imem_rvalid, imem_gnt}
        !== {1'b0, 1'b1, 32'hCAFE, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL stall_resp req=%b drv=%b drd=%h irv=%b ig=%b",
               mem_req, dmem_rvalid, dmem_rdata, imem_rvalid, imem_gnt);
    end
    next_cycle();
    mem_rvalid = 0; mem_rdata = 0;
    #1;
    n_cmp++;
    if (imem_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_next_gnt got=%b want=1", imem_gnt);
    end
    next_cycle();
    imem_req = 0; mem_ready = 1;
    next_cycle();
    mem_ready = 0;
  endtask

  task automatic test_reset_mid();
    #1;
    reset = 1;
    imem_req = 1; dmem_req = 1; mem_ready = 1;
    mem_rvalid = 1; mem_rdata = 32'h1111;
    #1;
    n_cmp++;
    if (all_out() !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs got=%h want=0", all_out());
    end
    next_cycle();
    clear_inputs();
    reset = 0;
    mem_rvalid = 1; mem_rdata = 32'hBAD0;
    #1;
    n_cmp++;
    if ({imem_rvalid, dmem_rvalid, imem_rdata, dmem_rdata, mem_req}
        !== '0) begin
      n_bad++;
      $display("FAIL rstmid_stray irv=%b drv=%b req=%b want 0",
               imem_rvalid, dmem_rvalid, mem_req);
    end
    next_cycle();
    mem_rvalid = 0; mem_rdata = 0;
    imem_req = 1; imem_addr = 32'h500; mem_ready = 1;
    #1;
    n_cmp++;
    if ({imem_gnt, dmem_gnt} !== 2'b10) begin
      n_bad++;
      $display("FAIL rstmid_gnt got=%b want=10", {imem_gnt, dmem_gnt});
    end
    next_cycle();
    imem_req = 0;
    #1;
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin
      n_bad++;
      $display("FAIL rstmid_req req=%b addr=%h want 1 500",
               mem_req, mem_addr);
    end
    next_cycle();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h600D;
    #1;
    n_cmp++;
    if ({imem_rvalid, imem_rdata, dmem_rvalid}
        !== {1'b1, 32'h600D, 1'b0}) begin
      n_bad++;
      $display("FAIL rstmid_rv irv=%b ird=%h drv=%b want 1 600d 0",
               imem_rvalid, imem_rdata, dmem_rvalid);
    end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_fetch_vs_store();
    test_starvation();
    test_ready_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
